// File: rtl/fetch_queue_pkg.sv
// Shared fetch-path constants and the fetch-entry record carried through the queue.
package fetch_queue_pkg;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;
  localparam logic [31:0] RESET_PC = 32'h0100_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch-queue signal bundle: PC-stage redirect, instruction-memory port and decode handshake.
interface fetch_queue_if;

  logic        flush;
  logic [31:0] pc_F;
  logic        stall_F;
  logic        imem_rd_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_pc;
  logic [31:0] dec_inst;

  // master: the fetch queue itself; slave: PC stage, memory and decode around it
  modport master (
    input  flush, pc_F, imem_data, dec_ready,
    output stall_F, imem_rd_en, imem_addr, dec_valid, dec_pc, dec_inst
  );

  modport slave (
    output flush, pc_F, imem_data, dec_ready,
    input  stall_F, imem_rd_en, imem_addr, dec_valid, dec_pc, dec_inst
  );

endinterface

// File: rtl/fetch_fifo.sv
// Circular store of fetched {pc, inst} entries with head/tail pointers and occupancy count.
module fetch_fifo
  import fetch_queue_pkg::fetch_entry_t;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clear,
  input  logic         push,
  input  fetch_entry_t push_entry,
  input  logic         pop,
  output fetch_entry_t head_entry,
  output logic [CW-1:0] count
);

  fetch_entry_t  mem [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;

  // DEPTH is a power of two, so pointer overflow is the modulo wrap
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (clear) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (push && !clear) mem[tail] <= push_entry;
  end

  assign head_entry = mem[head];

endmodule

// File: rtl/fetch_queue.sv
// Decoupling queue between the PC stage and decode: issues imem reads, tracks the one in-flight read, buffers returns.
module fetch_queue
  import fetch_queue_pkg::fetch_entry_t, fetch_queue_pkg::RESET_PC;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] NOP_INST = fetch_queue_pkg::NOP_INST
) (
  input  logic          clock,
  input  logic          reset,
  fetch_queue_if.master fq
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic          inflight_valid;
  logic [31:0]   inflight_pc;
  logic [CW-1:0] count;
  logic [CW-1:0] occupancy;
  logic          push;
  logic          pop;
  logic          dec_valid;
  fetch_entry_t  push_entry;
  fetch_entry_t  head_entry;

  // The in-flight read owns a slot, so stalling on count+inflight keeps pushes off a full queue
  assign occupancy     = count + CW'(inflight_valid);
  assign fq.stall_F    = !fq.flush && (occupancy >= CW'(DEPTH));
  assign fq.imem_rd_en = !reset && !fq.flush && !fq.stall_F;
  assign fq.imem_addr  = fq.pc_F;

  assign push       = inflight_valid && !fq.flush;
  assign pop        = dec_valid && fq.dec_ready && !fq.flush;
  assign push_entry = '{pc: inflight_pc, inst: fq.imem_data};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      inflight_valid <= 1'b0;
      inflight_pc    <= RESET_PC;
    end else begin
      inflight_valid <= fq.imem_rd_en;
      if (fq.imem_rd_en) inflight_pc <= fq.pc_F;
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock      (clock),
    .reset      (reset),
    .clear      (fq.flush),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .head_entry (head_entry),
    .count      (count)
  );

  assign dec_valid    = (count != '0);
  assign fq.dec_valid = dec_valid;
  assign fq.dec_pc    = dec_valid ? head_entry.pc   : 32'h0;
  assign fq.dec_inst  = dec_valid ? head_entry.inst : NOP_INST;

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: directed phases push expected PCs, a negedge monitor checks every accepted entry.
module tb_fetch_queue;

  localparam logic [31:0] RST_PC = 32'h0100_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_total = 0;
  int   n_pass  = 0;
  logic [31:0] exp_q [$];

  fetch_queue_if fq ();

  fetch_queue #(.DEPTH(4), .NOP_INST(NOP)) dut (
    .clock (clock),
    .reset (reset),
    .fq    (fq.master)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_0000;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, req);
  endtask

  task automatic push_exp(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(base + 32'(4 * i));
  endtask

  // One clock: memory answers one cycle after an accepted read, PC stage advances on issue
  task automatic tick();
    logic        issued;
    logic [31:0] addr;
    #1;
    issued = fq.imem_rd_en;
    addr   = fq.imem_addr;
    @(posedge clock);
    #1;
    if (issued) begin
      fq.imem_data = mem_fn(addr);
      fq.pc_F      = fq.pc_F + 32'd4;
    end else begin
      fq.imem_data = 32'h0;
    end
  endtask

  task automatic do_reset();
    reset        = 1'b1;
    fq.flush     = 1'b0;
    fq.dec_ready = 1'b0;
    fq.pc_F      = RST_PC;
    fq.imem_data = 32'h0;
    #1;
    check("rst_dec_valid", 32'(fq.dec_valid), 32'h0);
    check("rst_stall_F", 32'(fq.stall_F), 32'h0);
    check("rst_imem_rd_en", 32'(fq.imem_rd_en), 32'h0);
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    exp_q.delete();
    #1;
    check("post_rst_dec_pc", fq.dec_pc, 32'h0);
    check("post_rst_dec_inst", fq.dec_inst, NOP);
  endtask

  task automatic expect_drained(input string name);
    @(negedge clock);
    #1;
    check(name, 32'(exp_q.size()), 32'h0);
  endtask

  always @(negedge clock) begin
    if (!reset && fq.dec_valid && fq.dec_ready && !fq.flush) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pop_pc", fq.dec_pc, 32'hFFFF_FFFF);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        check("pop_pc", fq.dec_pc, e);
        check("pop_inst", fq.dec_inst, mem_fn(e));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d/%0d", n_pass, n_total);
    $fatal(1);
  end

  initial begin
    // Streaming with decode always ready: 2-cycle latency, then one PC per cycle
    do_reset();
    fq.dec_ready = 1'b1;
    push_exp(RST_PC, 7);
    tick();
    check("lat_cycle1_valid", 32'(fq.dec_valid), 32'h0);
    tick();
    check("lat_cycle2_valid", 32'(fq.dec_valid), 32'h1);
    check("lat_cycle2_pc", fq.dec_pc, RST_PC);
    repeat (6) tick();
    expect_drained("stream_drained");

    // Decode blocked: queue fills, fetch stalls, then drains in order
    do_reset();
    repeat (10) tick();
    check("full_count", 32'(dut.u_fifo.count), 32'd4);
    check("full_stall_F", 32'(fq.stall_F), 32'h1);
    check("full_rd_en", 32'(fq.imem_rd_en), 32'h0);
    check("full_head_pc", fq.dec_pc, RST_PC);
    push_exp(RST_PC, 8);
    fq.dec_ready = 1'b1;
    repeat (7) tick();
    expect_drained("backpressure_drained");

    // Flush with three queued and one in flight, redirect to 0x01000080
    do_reset();
    repeat (4) tick();
    check("pre_flush_count", 32'(dut.u_fifo.count), 32'd3);
    fq.flush = 1'b1;
    fq.pc_F  = 32'h0100_0080;
    tick();
    fq.flush = 1'b0;
    #1;
    check("flush_dec_valid", 32'(fq.dec_valid), 32'h0);
    check("flush_dec_inst", fq.dec_inst, NOP);
    check("flush_dec_pc", fq.dec_pc, 32'h0);
    check("redirect_rd_en", 32'(fq.imem_rd_en), 32'h1);
    check("redirect_addr", fq.imem_addr, 32'h0100_0080);
    fq.dec_ready = 1'b1;
    push_exp(32'h0100_0080, 3);
    repeat (4) tick();
    expect_drained("flush_drained");

    // Pop on the cycle the in-flight entry lands in the last free slot (tail wraps)
    do_reset();
    repeat (4) tick();
    check("near_full_stall", 32'(fq.stall_F), 32'h1);
    fq.dec_ready = 1'b1;
    push_exp(RST_PC, 7);
    tick();
    check("pushpop_count", 32'(dut.u_fifo.count), 32'd3);
    check("tail_wrapped", 32'(dut.u_fifo.tail), 32'd0);
    check("pushpop_stall", 32'(fq.stall_F), 32'h0);
    repeat (5) tick();
    expect_drained("wrap_drained");

    // Asynchronous reset between edges with two entries queued
    do_reset();
    repeat (3) tick();
    check("pre_async_valid", 32'(fq.dec_valid), 32'h1);
    #3;
    reset = 1'b1;
    #1;
    check("async_dec_valid", 32'(fq.dec_valid), 32'h0);
    check("async_dec_inst", fq.dec_inst, NOP);
    check("async_rd_en", 32'(fq.imem_rd_en), 32'h0);
    check("async_count", 32'(dut.u_fifo.count), 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    #1;
    check("after_async_valid", 32'(fq.dec_valid), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
